// File: rtl/soc_clock_gate_ctrl.sv
// rtl/soc_clock_gate_ctrl.sv - enable-side controller for the core clock gate
// Idle hysteresis before gating, settle window after wake, saturating wake-event counter.
module soc_clock_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sleep_req_i,
  input  logic             wake_irq_i,
  input  logic             debug_req_i,
  input  logic             force_on_i,
  input  logic             test_mode_i,
  output logic             clk_en_o,
  output logic             scan_cg_en_o,
  output logic             gated_o,
  output logic [CNT_W-1:0] wake_cnt_o
);

  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 255) begin : g_bad_idle
    $error("IDLE_CYCLES must be in 1..255");
  end
  if (WAKE_CYCLES < 1 || WAKE_CYCLES > 255) begin : g_bad_wake
    $error("WAKE_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_RUN,
    ST_IDLE_WAIT,
    ST_GATED,
    ST_WAKE
  } state_t;

  localparam logic [7:0] IDLE_LOAD = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             en_q;
  logic             gated_q;
  logic [CNT_W-1:0] wake_cnt_q;
  logic             sleep_q;
  logic             wake_q;
  logic             qualify;
  logic             wake_evt;

  // Inputs are captured once; the FSM acts on the sampled copy one edge later.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wake_evt = 1'b0;
    qualify  = sleep_q & ~wake_q;
    case (state_q)
      ST_RUN: begin
        if (qualify) begin
          state_d = ST_IDLE_WAIT;
          cnt_d   = IDLE_LOAD;
        end
      end
      ST_IDLE_WAIT: begin
        if (!qualify) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_GATED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GATED: begin
        if (wake_q || !sleep_q) begin
          state_d  = ST_WAKE;
          cnt_d    = WAKE_LOAD;
          wake_evt = 1'b1;
        end
      end
      ST_WAKE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      cnt_q      <= 8'd0;
      en_q       <= 1'b1;
      gated_q    <= 1'b0;
      wake_cnt_q <= '0;
      sleep_q    <= 1'b0;
      wake_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= (state_d != ST_GATED);
      gated_q <= (state_d == ST_GATED);
      sleep_q <= sleep_req_i;
      wake_q  <= wake_irq_i | debug_req_i | force_on_i;
      if (wake_evt && (wake_cnt_q != '1)) begin
        wake_cnt_q <= wake_cnt_q + CNT_W'(1);
      end
    end
  end

  assign clk_en_o     = en_q | test_mode_i;
  assign scan_cg_en_o = test_mode_i;
  assign gated_o      = gated_q;
  assign wake_cnt_o   = wake_cnt_q;

endmodule

// File: tb/tb_soc_clock_gate_ctrl.sv
// tb/tb_soc_clock_gate_ctrl.sv - self-checking bench for soc_clock_gate_ctrl
// Vector table with hand-computed expectations, routed through an expected-result queue.
module tb_soc_clock_gate_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sleep, irq, dbg, frc, tm;
  logic en1, scan1, g1;
  logic [15:0] cnt1;
  logic en2, scan2, g2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;
  int vidx = 0;

  typedef struct {
    logic rst, sleep, irq, dbg, frc, tm;
    logic en, gated, scan;
    int   cnt;
  } vec_t;

  typedef struct {
    logic en, gated, scan;
    int   cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  soc_clock_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .sleep_req_i(sleep), .wake_irq_i(irq),
    .debug_req_i(dbg), .force_on_i(frc), .test_mode_i(tm),
    .clk_en_o(en1), .scan_cg_en_o(scan1), .gated_o(g1), .wake_cnt_o(cnt1)
  );

  soc_clock_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .sleep_req_i(sleep), .wake_irq_i(irq),
    .debug_req_i(dbg), .force_on_i(frc), .test_mode_i(tm),
    .clk_en_o(en2), .scan_cg_en_o(scan2), .gated_o(g2), .wake_cnt_o(cnt2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic i, input logic d,
                     input logic f, input logic t, input logic e, input logic g,
                     input int c);
    vec_t v;
    v.rst = r; v.sleep = s; v.irq = i; v.dbg = d; v.frc = f; v.tm = t;
    v.en = e; v.gated = g; v.scan = t; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    int   sat;
    rst = v.rst; sleep = v.sleep; irq = v.irq; dbg = v.dbg; frc = v.frc; tm = v.tm;
    e.en = v.en; e.gated = v.gated; e.scan = v.scan; e.cnt = v.cnt;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    sat = (e.cnt > 3) ? 3 : e.cnt;
    chk($sformatf("v%0d clk_en", vidx), int'(en1), int'(e.en));
    chk($sformatf("v%0d gated", vidx), int'(g1), int'(e.gated));
    chk($sformatf("v%0d scan_cg_en", vidx), int'(scan1), int'(e.scan));
    chk($sformatf("v%0d wake_cnt", vidx), int'(cnt1), e.cnt);
    chk($sformatf("v%0d sat_clk_en", vidx), int'(en2), int'(e.en));
    chk($sformatf("v%0d sat_wake_cnt", vidx), int'(cnt2), sat);
    vidx++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   c;
    rst = 1'b1; sleep = 1'b0; irq = 1'b0; dbg = 1'b0; frc = 1'b0; tm = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset clk_en", int'(en1), 1);
    chk("reset gated", int'(g1), 0);
    chk("reset wake_cnt", int'(cnt1), 0);
    chk("reset scan_cg_en", int'(scan1), 0);

    c = 0;
    // gate entry: clock drops on the 6th edge after sleep is driven
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 1, 0, c);
    add(0, 1, 0, 0, 0, 0, 0, 1, c);
    add(0, 1, 0, 0, 0, 0, 0, 1, c);
    // one-cycle debug pulse wakes; sleep still high re-gates after WAKE then IDLE
    add(0, 1, 0, 1, 0, 0, 0, 1, c);
    c++;
    for (int i = 0; i < 7; i++) add(0, 1, 0, 0, 0, 0, 1, 0, c);
    add(0, 1, 0, 0, 0, 0, 0, 1, c);
    // test mode forces the enable while the FSM stays gated
    add(0, 1, 0, 0, 0, 1, 1, 1, c);
    add(0, 1, 0, 0, 0, 0, 0, 1, c);
    // exit on sleep release
    add(0, 0, 0, 0, 0, 0, 0, 1, c);
    c++;
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 0, c);
    // abort during idle wait
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 1, 0, c);
    add(0, 1, 1, 0, 0, 0, 1, 0, c);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 0, c);
    // wake on the cnt==0 edge returns to RUN, then re-qualifies from scratch
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 1, 0, c);
    add(0, 1, 1, 0, 0, 0, 1, 0, c);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 1, 0, c);
    add(0, 1, 0, 0, 0, 0, 0, 1, c);
    add(0, 0, 0, 0, 0, 0, 0, 1, c);
    c++;
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 0, c);
    // two more full sleep/wake rounds to push the 2-bit counter past saturation
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 1, 0, c);
      add(0, 1, 0, 0, 0, 0, 0, 1, c);
      add(0, 0, 0, 0, 0, 0, 0, 1, c);
      c++;
      for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 0, c);
    end

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // force_on overrides a held sleep request
    for (int i = 0; i < 100; i++) begin
      v.rst = 0; v.sleep = 1; v.irq = 0; v.dbg = 0; v.frc = 1; v.tm = 0;
      v.en = 1; v.gated = 0; v.scan = 0; v.cnt = c;
      apply(v);
    end
    v.sleep = 0; v.frc = 0;
    apply(v);
    apply(v);

    // reset while gated
    v.sleep = 1;
    for (int i = 0; i < 5; i++) apply(v);
    v.en = 0; v.gated = 1;
    apply(v);
    v.rst = 1; v.en = 1; v.gated = 0; v.cnt = 0;
    apply(v);
    v.rst = 0; v.sleep = 0;
    apply(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
